uart_xmit_arb: RTL and testbench

UART_XMIT_ARB -- requirements
Module: uart_xmit_arb

---
 rtl/uart_xmit_arb_if.sv | 39 +++
 rtl/uart_xmit_arb.sv | 162 ++++++++++++++++
 tb/tb_uart_xmit_arb.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_xmit_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_xmit_arb_if
// Description : Bundles the signals between the two byte requesters, the
//               UART transmitter and the uart_xmit_arb arbiter.
//               slave  - arbiter side (drives acks and the transmitter strobe)
//               master - environment side (requesters and transmitter status)
// Signals     : req_a/data_a/ack_a     requester A handshake
//               req_b/data_b/ack_b     requester B handshake
//               xmitH/xmit_dataH       start strobe and byte to the UART
//               xmit_doneH             UART idle flag (1 = idle)
//               busy/last_grant/tx_err arbiter status
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_xmit_arb_if;
  logic       req_a;
  logic [7:0] data_a;
  logic       ack_a;
  logic       req_b;
  logic [7:0] data_b;
  logic       ack_b;
  logic       xmitH;
  logic [7:0] xmit_dataH;
  logic       xmit_doneH;
  logic       busy;
  logic       last_grant;
  logic       tx_err;

  modport slave (
    input  req_a, data_a, req_b, data_b, xmit_doneH,
    output ack_a, ack_b, xmitH, xmit_dataH, busy, last_grant, tx_err
  );

  modport master (
    output req_a, data_a, req_b, data_b, xmit_doneH,
    input  ack_a, ack_b, xmitH, xmit_dataH, busy, last_grant, tx_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_xmit_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_xmit_arb
// Description : Round-robin arbiter feeding bytes from two requesters into a
//               single UART transmitter. A grant latches the chosen byte and
//               acks the requester; one cycle later xmitH strobes the UART,
//               then the arbiter waits for the transmitter to go busy and
//               return to idle before the next grant.
// Ports       : sys_clk    - clock, rising edge
//               sys_rst_l  - asynchronous active-low reset
//               arb        - uart_xmit_arb_if.slave (requesters, UART, status)
// Parameters  : TIMEOUT_W   - watchdog counter width
//               TIMEOUT_MAX - watchdog terminal count in sys_clk cycles
// Build macro : UART_XMIT_ARB_TIMEOUT_EN - enables the transfer watchdog and
//               the sticky tx_err flag; when undefined tx_err is tied low and
//               the wait states never time out.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_xmit_arb #(
  parameter int unsigned          TIMEOUT_W   = 12,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 12'hFFF
) (
  input  wire logic      sys_clk,
  input  wire logic      sys_rst_l,
  uart_xmit_arb_if.slave arb
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t     state_q;
  logic       ack_a_q;
  logic       ack_b_q;
  logic       xmitH_q;
  logic       busy_q;
  logic       last_grant_q;
  logic [7:0] xmit_data_q;

  logic       req_any_d;
  logic       grant_b_d;
  logic       wd_expired_d;

  // Round-robin: a contested grant goes to the requester that did not win
  // last time; an uncontested one goes to whoever is asking.
  always_comb begin
    req_any_d = arb.req_a | arb.req_b;
    if (arb.req_a && arb.req_b) begin
      grant_b_d = ~last_grant_q;
    end else begin
      grant_b_d = arb.req_b;
    end
  end

`ifdef UART_XMIT_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q;
  logic [TIMEOUT_W-1:0] wd_d;
  logic                 tx_err_q;

  // Expiry only matters while waiting on the transmitter.
  always_comb begin
    wd_expired_d = (wd_q == TIMEOUT_MAX) &&
                   ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE));
  end

  // The counter runs from S_LOAD onward and is cleared on every path back
  // to S_IDLE so each transfer starts from zero.
  always_comb begin
    wd_d = wd_q + 1'b1;
    if ((state_q == S_IDLE) || wd_expired_d ||
        ((state_q == S_WAIT_DONE) && arb.xmit_doneH)) begin
      wd_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wd_q     <= '0;
      tx_err_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (wd_expired_d && !((state_q == S_WAIT_DONE) && arb.xmit_doneH)) begin
        tx_err_q <= 1'b1;
      end
    end
  end

  assign arb.tx_err = tx_err_q;
`else
  always_comb begin
    wd_expired_d = 1'b0;
  end

  assign arb.tx_err = 1'b0;
`endif

  // Single FSM process; every output is a register updated alongside the
  // state so nothing combinational reaches the ports.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q      <= S_IDLE;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      xmitH_q      <= 1'b0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
      xmit_data_q  <= 8'h00;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      xmitH_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb.xmit_doneH && req_any_d) begin
            state_q      <= S_LOAD;
            busy_q       <= 1'b1;
            last_grant_q <= grant_b_d;
            ack_a_q      <= ~grant_b_d;
            ack_b_q      <= grant_b_d;
            xmit_data_q  <= grant_b_d ? arb.data_b : arb.data_a;
          end
        end
        S_LOAD: begin
          // Registered here, so the strobe is visible one cycle after the ack.
          state_q <= S_WAIT_BUSY;
          xmitH_q <= 1'b1;
        end
        S_WAIT_BUSY: begin
          if (wd_expired_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (!arb.xmit_doneH) begin
            state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          // A completed frame wins over a same-cycle watchdog expiry.
          if (arb.xmit_doneH || wd_expired_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign arb.ack_a      = ack_a_q;
  assign arb.ack_b      = ack_b_q;
  assign arb.xmitH      = xmitH_q;
  assign arb.xmit_dataH = xmit_data_q;
  assign arb.busy       = busy_q;
  assign arb.last_grant = last_grant_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_xmit_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_xmit_arb
// Description : Self-checking bench for uart_xmit_arb. A directed vector
//               table, hand-written reset/watchdog sequences and a random
//               traffic phase checked against a transaction-level model.
//               Output word compared everywhere:
//               {ack_a, ack_b, xmitH, busy, last_grant, tx_err, xmit_dataH}
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_xmit_arb;

  localparam int             TMAX_I = 40;
  localparam logic [11:0]    TMAX   = 12'd40;
  localparam logic [13:0]    RV     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  uart_xmit_arb_if bus();

  uart_xmit_arb #(
    .TIMEOUT_W   (12),
    .TIMEOUT_MAX (TMAX)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_l (rst_l),
    .arb       (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       ra;
    logic [7:0] da;
    logic       rb;
    logic [7:0] db;
    logic       dn;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl [29];

  function automatic logic [13:0] mk(input logic aa, input logic ab, input logic x,
                                     input logic b, input logic l, input logic [7:0] d);
    return {aa, ab, x, b, l, 1'b0, d};
  endfunction

  function automatic logic [13:0] outs();
    return {bus.ack_a, bus.ack_b, bus.xmitH, bus.busy, bus.last_grant, bus.tx_err, bus.xmit_dataH};
  endfunction

  task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (ackA ackB xmit busy last err data)", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ra, input logic [7:0] da, input logic rb,
                       input logic [7:0] db, input logic dn);
    bus.req_a = ra; bus.data_a = da; bus.req_b = rb; bus.data_b = db; bus.xmit_doneH = dn;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    rst_l = 1'b0;
    #1;
    chk("reset_state", outs(), RV);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  // Random-phase model state
  logic       pa, pb, u_done;
  logic [7:0] da, db;
  logic       m_free, m_last, m_low, ea, eb, gb;
  logic [7:0] m_data;
  int         m_due, u_mode, u_cnt;

  initial begin
    rst_l = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    #2;
    do_reset();

    // Directed table: single requester, data change after ack, grant blocked
    // by a busy transmitter, then contested requests alternating A/B.
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, mk(1,0,0,1,0,8'hA5)};
    tbl[1]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, mk(0,0,1,1,0,8'hA5)};
    tbl[2]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, mk(0,0,0,1,0,8'hA5)};
    tbl[3]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, mk(0,0,0,1,0,8'hA5)};
    tbl[4]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, mk(0,0,0,1,0,8'hA5)};
    tbl[5]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, mk(0,0,0,0,0,8'hA5)};
    tbl[6]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, mk(1,0,0,1,0,8'hFF)};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, mk(0,0,1,1,0,8'hFF)};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, mk(0,0,0,1,0,8'hFF)};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, mk(0,0,0,0,0,8'hFF)};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, mk(0,0,0,0,0,8'hFF)};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, mk(0,0,0,0,0,8'hFF)};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, mk(0,1,0,1,1,8'h3C)};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, mk(0,0,1,1,1,8'h3C)};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, mk(0,0,0,1,1,8'h3C)};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, mk(0,0,0,0,1,8'h3C)};
    tbl[16] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, mk(1,0,0,1,0,8'h11)};
    tbl[17] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, mk(0,0,1,1,0,8'h11)};
    tbl[18] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, mk(0,0,0,1,0,8'h11)};
    tbl[19] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, mk(0,0,0,0,0,8'h11)};
    tbl[20] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, mk(0,1,0,1,1,8'h22)};
    tbl[21] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, mk(0,0,1,1,1,8'h22)};
    tbl[22] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, mk(0,0,0,1,1,8'h22)};
    tbl[23] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, mk(0,0,0,0,1,8'h22)};
    tbl[24] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, mk(1,0,0,1,0,8'h11)};
    tbl[25] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, mk(0,0,1,1,0,8'h11)};
    tbl[26] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, mk(0,0,0,1,0,8'h11)};
    tbl[27] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, mk(0,0,0,0,0,8'h11)};
    tbl[28] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, mk(0,1,0,1,1,8'h22)};

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].ra, tbl[i].da, tbl[i].rb, tbl[i].db, tbl[i].dn);
      @(posedge clk); #1;
      chk($sformatf("table[%0d]", i), outs(), tbl[i].exp);
    end

    // Reset while waiting for the frame to finish.
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    @(posedge clk); #1; chk("abort_xmit", outs(), mk(0,0,1,1,1,8'h22));
    bus.xmit_doneH = 1'b0;
    @(posedge clk); #1; chk("abort_wait1", outs(), mk(0,0,0,1,1,8'h22));
    @(posedge clk); #1; chk("abort_wait2", outs(), mk(0,0,0,1,1,8'h22));
    #2 rst_l = 1'b0;
    #1 chk("async_reset", outs(), RV);
    @(posedge clk); #1; chk("reset_hold", outs(), RV);
    @(negedge clk);
    rst_l = 1'b1;
    bus.xmit_doneH = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; chk("no_reissue", outs(), RV);
    end
    drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    @(posedge clk); #1; chk("post_reset_grant", outs(), mk(1,0,0,1,0,8'h5A));
    bus.req_a = 1'b0;
    @(posedge clk); #1; chk("post_reset_xmit", outs(), mk(0,0,1,1,0,8'h5A));

    // Random traffic against a transaction-level model.
    do_reset();
    pa = 1'b0; pb = 1'b0; da = 8'h00; db = 8'h00; u_done = 1'b1;
    m_free = 1'b1; m_last = 1'b1; m_low = 1'b0; m_data = 8'h00; m_due = -100;
    u_mode = 0; u_cnt = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      ea = 1'b0; eb = 1'b0;
      if (m_free) begin
        if (u_done && (pa || pb)) begin
          gb     = (pa && pb) ? ~m_last : pb;
          ea     = ~gb;
          eb     = gb;
          m_last = gb;
          m_data = gb ? db : da;
          m_free = 1'b0;
          m_low  = 1'b0;
          m_due  = cyc + 1;
        end
      end else if (cyc > m_due) begin
        if (!u_done) m_low = 1'b1;
        else if (m_low) m_free = 1'b1;
      end
      @(posedge clk); #1;
      chk("random", outs(), {ea, eb, (cyc == m_due), ~m_free, m_last, 1'b0, m_data});

      // Requesters: drop and scramble data after ack, re-request at random.
      if (ea) begin pa = 1'b0; da = 8'($urandom); end
      else if (!pa && ($urandom % 3 == 0)) begin pa = 1'b1; da = 8'($urandom); end
      if (eb) begin pb = 1'b0; db = 8'($urandom); end
      else if (!pb && ($urandom % 3 == 0)) begin pb = 1'b1; db = 8'($urandom); end

      // Transmitter: goes busy a little after the strobe, finishes later;
      // occasionally busy on its own while the arbiter is idle.
      if (cyc == m_due) begin u_mode = 1; u_cnt = $urandom_range(0, 3); end
      case (u_mode)
        0: if (m_free && ($urandom % 8 == 0)) begin
             u_done = 1'b0; u_mode = 3; u_cnt = $urandom_range(1, 3);
           end
        1: if (u_cnt == 0) begin
             u_done = 1'b0; u_mode = 2; u_cnt = $urandom_range(1, 5);
           end else begin
             u_cnt--;
           end
        default: begin
          u_cnt--;
          if (u_cnt == 0) begin u_done = 1'b1; u_mode = 0; end
        end
      endcase
      drive(pa, da, pb, db, u_done);
    end

    // Transmitter never finishes.
    do_reset();
    drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    @(posedge clk); #1; chk("to_grant", outs(), mk(1,0,0,1,0,8'h77));
    bus.req_a = 1'b0;
    @(posedge clk); #1; chk("to_xmit", outs(), mk(0,0,1,1,0,8'h77));
    bus.xmit_doneH = 1'b0;
`ifdef UART_XMIT_ARB_TIMEOUT_EN
    begin
      int  cnt;
      logic got;
      cnt = 0; got = 1'b0;
      while (!got && cnt < TMAX_I + 20) begin
        @(posedge clk); #1;
        cnt++;
        if (!bus.busy) got = 1'b1;
      end
      n_vec++;
      if (!got || cnt < TMAX_I - 1 || cnt > TMAX_I + 1) begin
        n_err++;
        $display("FAIL timeout_latency: idle seen=%0d after %0d cycles, required about %0d", got, cnt, TMAX_I);
      end
      chk("timeout_err", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77});
      drive(1'b0, 8'h00, 1'b1, 8'h99, 1'b1);
      @(posedge clk); #1; chk("err_sticky_grant", outs(), {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h99});
      bus.req_b = 1'b0;
      @(posedge clk); #1; chk("err_sticky_xmit", outs(), {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h99});
    end
`else
    repeat (TMAX_I + 20) @(posedge clk);
    #1; chk("no_timeout", outs(), mk(0,0,0,1,0,8'h77));
    bus.xmit_doneH = 1'b1;
    @(posedge clk); #1; chk("late_done", outs(), mk(0,0,0,0,0,8'h77));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
